icache_ctrl: RTL and testbench
==============================

// Module: icache_ctrl
// PURPOSE
// Direct-mapped instruction cache controller between the fetch stage and the
// 8-word-wide instruction memory. Serves hits combinationally from a local
// line array. On a miss it stalls fetch, issues one line address to IMEM,
// waits FILL_LAT cycles and writes the returned 256-bit line. Keeps hit and
// miss statistics counters.
// PARAMETERS
// LINES     16  number of cache lines; power of 2, >= 2
// FILL_LAT  4   cycles IMEM takes to return a line after mem_req; >= 1
// CNT_W     32  width of the hit/miss statistics counters
// PORTS
// CLK       in   1      system clock, rising edge
// RST       in   1      synchronous, active-high reset
// fetch_en  in   1      fetch stage requests the instruction at pc this cycle
// pc        in   32     fetch byte address, word aligned; pc[1:0] ignored
// flush     in   1      invalidate all lines (fence.i)
// instr     out  32     instruction word; valid when fetch_en & ~stall
// stall     out  1      fetch must hold pc and retry next cycle
// mem_req   out  1      line fill in progress; IMEM address is valid
// mem_addr  out  32     line-aligned fill address {tag, index, 5'b0}
// mem_line  in   256    IMEM line {w7,...,w0}; w0 is at mem_addr
// hit_cnt   out  CNT_W  count of served hits, saturating
// miss_cnt  out  CNT_W  count of misses, saturating
// BEHAVIOUR
// - Address split: offset = pc[4:2]; index = pc[5+IW-1:5] with IW = log2(LINES);
//   tag = pc[31:5+IW].
// - Per line: valid bit, tag register, 8 x 32b data. Only valid and tag are reset.
// - Reset (RST high at an edge): state=LOOKUP, all valid=0, mem_req=0,
//   mem_addr=0, fill counter=0, hit_cnt=0, miss_cnt=0. RST wins over flush.
// - hit = (state==LOOKUP) & valid[index] & (tag_ram[index]==tag).
// - instr = hit ? data[index][offset] : 32'h00000013 (NOP).
// - stall = (state!=LOOKUP) | (fetch_en & ~hit).
// - FSM states are LOOKUP, FILL and UPDATE.
// - LOOKUP, fetch_en & hit: no stall. hit_cnt increments at the edge.
// - LOOKUP, fetch_en & miss: stall=1. miss_cnt increments at the edge.
//   mem_addr <= {pc[31:5],5'b0}, mem_req <= 1, cnt <= FILL_LAT-1, go to FILL.
// - LOOKUP, fetch_en=0: idle, no counting.
// - FILL: mem_req=1 and stall=1. If cnt!=0, cnt decrements. If cnt==0, at the
//   edge: write mem_line to data[idx(mem_addr)], write the tag, set valid,
//   mem_req <= 0, go to UPDATE.
// - UPDATE: one cycle with stall=1, mem_req=0, then go to LOOKUP.
// - Miss timing: miss seen in cycle 0. FILL occupies cycles 1..FILL_LAT.
//   UPDATE is cycle FILL_LAT+1. Re-lookup hits in cycle FILL_LAT+2.
//   A miss therefore costs FILL_LAT+2 stall cycles.
// - The re-lookup after a fill counts as a hit.
// - The fill uses the latched mem_addr, so pc changes during FILL/UPDATE do not
//   corrupt it. After UPDATE the current pc is looked up again.
// - A fill overwrites the previous line at that index (no replacement choice).
// - flush, any state: at the edge all valid <= 0, state <= LOOKUP, mem_req <= 0.
//   An in-progress fill is abandoned and no line is written.
// - flush in LOOKUP with a hit: instr is still served that cycle and hit_cnt
//   counts it. Valid bits clear at the edge.
// - flush does not reset the counters. Both counters hold at 2^CNT_W-1.
// - pc[1:0] is ignored.
// TESTING
// - Reset, fetch_en=1, pc=0x0000_0000 -> stall high for 6 cycles (FILL_LAT=4).
//   mem_addr=0x0, mem_req high for 4 cycles. Then instr=mem_line[31:0],
//   miss_cnt=1, hit_cnt=1.
// - After that fill, pc=0x1C -> hit with no stall, instr=w7.
//   pc=0x20 -> miss, mem_addr=0x20.
// - Conflict: fill pc=0x000, then pc=0x200 (same index 0, LINES=16) -> miss,
//   line replaced. pc=0x000 then misses again. miss_cnt=3.
// - flush asserted during FILL cycle 2 -> next cycle state=LOOKUP, mem_req=0,
//   no line written. Same pc misses again.
// - flush in LOOKUP on a hit -> instr valid that cycle. Next fetch of that pc
//   misses.
// - RST asserted mid-FILL -> next cycle all outputs at reset values, counters=0.
//   CNT_W=4 with 20 hits -> hit_cnt holds at 15.

Source files
------------

// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache controller: combinational hit path, single
// outstanding line fill from IMEM, saturating hit/miss statistics.
module icache_ctrl #(
  parameter int unsigned LINES    = 16,
  parameter int unsigned FILL_LAT = 4,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             fetch_en,
  input  logic [31:0]      pc,
  input  logic             flush,
  output logic [31:0]      instr,
  output logic             stall,
  output logic             mem_req,
  output logic [31:0]      mem_addr,
  input  logic [255:0]     mem_line,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam int unsigned IW = $clog2(LINES);
  localparam int unsigned TW = 27 - IW;
  localparam int unsigned CW = $clog2(FILL_LAT + 1);

  typedef enum logic [1:0] {StLookup, StFill, StUpdate} state_e;

  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    mem_req_q, mem_req_d;
  logic [31:0]             mem_addr_q, mem_addr_d;
  logic [CNT_W-1:0]        hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]        miss_cnt_q, miss_cnt_d;
  logic [LINES-1:0]        valid_q;
  logic [TW-1:0]           tag_q  [LINES];
  logic [255:0]            data_q [LINES];

  logic [IW-1:0]           idx, fill_idx;
  logic [TW-1:0]           tag, fill_tag;
  logic [2:0]              off;
  logic                    hit, fill_we;
  logic                    unused_pc;

  assign idx       = pc[5+IW-1:5];
  assign tag       = pc[31:5+IW];
  assign off       = pc[4:2];
  assign fill_idx  = mem_addr_q[5+IW-1:5];
  assign fill_tag  = mem_addr_q[31:5+IW];
  assign unused_pc = ^pc[1:0];

  assign hit      = (state_q == StLookup) && valid_q[idx] && (tag_q[idx] == tag);
  assign instr    = hit ? data_q[idx][{off, 5'b0} +: 32] : 32'h0000_0013;
  assign stall    = (state_q != StLookup) || (fetch_en && !hit);
  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    fill_we    = 1'b0;
    unique case (state_q)
      StLookup: begin
        if (fetch_en && !hit) begin
          state_d    = StFill;
          mem_req_d  = 1'b1;
          mem_addr_d = {pc[31:5], 5'b0};
          cnt_d      = CW'(FILL_LAT - 1);
        end
      end
      StFill: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          fill_we   = 1'b1;
          mem_req_d = 1'b0;
          state_d   = StUpdate;
        end
      end
      StUpdate: state_d = StLookup;
      default:  state_d = StLookup;
    endcase
    // Flush abandons any fill in flight; nothing gets written.
    if (flush) begin
      state_d   = StLookup;
      mem_req_d = 1'b0;
      fill_we   = 1'b0;
    end
  end

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (fetch_en && hit && (hit_cnt_q != '1)) hit_cnt_d = hit_cnt_q + CNT_W'(1);
    if (fetch_en && !hit && (state_q == StLookup) && (miss_cnt_q != '1)) begin
      miss_cnt_d = miss_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= StLookup;
      cnt_q      <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      valid_q    <= '0;
      for (int i = 0; i < LINES; i++) tag_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      if (flush) begin
        valid_q <= '0;
      end else if (fill_we) begin
        valid_q[fill_idx] <= 1'b1;
        tag_q[fill_idx]   <= fill_tag;
      end
    end
  end

  // Line data carries no reset; valid bits guard it.
  always_ff @(posedge CLK) begin
    if (fill_we && !RST) data_q[fill_idx] <= mem_line;
  end

endmodule

// File: tb/tb_icache_ctrl.sv
// Scoreboard bench for icache_ctrl: directed fetches push expected words,
// a negedge monitor checks every served instruction.
module tb_icache_ctrl;

  localparam int unsigned LINES    = 16;
  localparam int unsigned FILL_LAT = 4;
  localparam int unsigned CNT_W    = 4;
  localparam logic [31:0] SALT     = 32'hA5C3_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             fetch_en = 1'b0;
  logic             flush = 1'b0;
  logic [31:0]      pc = '0;
  logic [31:0]      instr;
  logic             stall;
  logic             mem_req;
  logic [31:0]      mem_addr;
  logic [255:0]     mem_line;
  logic [CNT_W-1:0] hit_cnt;
  logic [CNT_W-1:0] miss_cnt;

  int total = 0;
  int bad   = 0;
  logic [31:0] sb[$];

  icache_ctrl #(
    .LINES   (LINES),
    .FILL_LAT(FILL_LAT),
    .CNT_W   (CNT_W)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .fetch_en(fetch_en),
    .pc      (pc),
    .flush   (flush),
    .instr   (instr),
    .stall   (stall),
    .mem_req (mem_req),
    .mem_addr(mem_addr),
    .mem_line(mem_line),
    .hit_cnt (hit_cnt),
    .miss_cnt(miss_cnt)
  );

  always #5 CLK = ~CLK;

  // IMEM: word i of a line encodes its own byte address.
  always_comb begin
    mem_line = '0;
    for (int i = 0; i < 8; i++) mem_line[i*32 +: 32] = SALT ^ {mem_addr[31:5], 3'(i), 2'b00};
  end

  function automatic logic [31:0] exp_word(input logic [31:0] a);
    return SALT ^ {a[31:2], 2'b00};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (!RST && fetch_en && !stall) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_instr: got %h want none (pc %h)", instr, pc);
      end else begin
        check("instr", instr, sb.pop_front());
      end
    end
  end

  task automatic do_reset();
    RST = 1'b1;
    fetch_en = 1'b0;
    flush = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
  endtask

  task automatic counts(input int h, input int m);
    check("hit_cnt", 32'(hit_cnt), 32'(h));
    check("miss_cnt", 32'(miss_cnt), 32'(m));
  endtask

  task automatic fetch(input logic [31:0] a, input int exp_stalls, input logic [31:0] exp_addr);
    int n = 0;
    int reqs = 0;
    logic [31:0] addr = '0;
    sb.push_back(exp_word(a));
    pc = a;
    fetch_en = 1'b1;
    @(negedge CLK);
    while (stall && n < 50) begin
      n++;
      if (mem_req) begin
        reqs++;
        addr = mem_addr;
      end
      @(negedge CLK);
    end
    if (n >= 50) void'(sb.pop_back());
    check("stall_cycles", 32'(n), 32'(exp_stalls));
    if (exp_stalls > 0) begin
      check("req_cycles", 32'(reqs), 32'(FILL_LAT));
      check("fill_addr", addr, exp_addr);
    end
    @(posedge CLK);
    #1 fetch_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_instr", instr, NOP);
    counts(0, 0);
    @(posedge CLK);
    #1;

    // Cold miss, then hits and a miss in the neighbouring line
    fetch(32'h0000_0000, 6, 32'h0);
    counts(1, 1);
    fetch(32'h0000_001C, 0, 32'h0);
    fetch(32'h0000_0020, 6, 32'h20);
    counts(3, 2);

    // Conflict on index 0
    do_reset();
    fetch(32'h0000_0000, 6, 32'h0);
    fetch(32'h0000_0200, 6, 32'h200);
    fetch(32'h0000_0000, 6, 32'h0);
    counts(3, 3);
    fetch(32'h0000_0003, 0, 32'h0);

    // Flush during fill cycle 2
    pc = 32'h40;
    fetch_en = 1'b1;
    @(posedge CLK);
    @(posedge CLK);
    #1 flush = 1'b1;
    @(posedge CLK);
    #1 flush = 1'b0;
    check("flush_fill_mem_req", 32'(mem_req), 32'd0);
    check("flush_fill_relookup_stall", 32'(stall), 32'd1);
    fetch_en = 1'b0;
    fetch(32'h0000_0040, 6, 32'h40);
    counts(5, 5);

    // Flush in LOOKUP on a hit still serves the word
    sb.push_back(exp_word(32'h40));
    pc = 32'h40;
    fetch_en = 1'b1;
    flush = 1'b1;
    @(negedge CLK);
    check("flush_hit_stall", 32'(stall), 32'd0);
    @(posedge CLK);
    #1 flush = 1'b0;
    fetch_en = 1'b0;
    fetch(32'h0000_0040, 6, 32'h40);
    counts(7, 6);

    // Reset mid-fill
    pc = 32'h80;
    fetch_en = 1'b1;
    @(posedge CLK);
    @(posedge CLK);
    #1 RST = 1'b1;
    @(posedge CLK);
    #1 RST = 1'b0;
    fetch_en = 1'b0;
    @(negedge CLK);
    check("rst_fill_mem_req", 32'(mem_req), 32'd0);
    check("rst_fill_mem_addr", mem_addr, 32'h0);
    check("rst_fill_stall", 32'(stall), 32'd0);
    check("rst_fill_instr", instr, NOP);
    counts(0, 0);
    @(posedge CLK);
    #1;

    // Hit counter saturates at 15
    fetch(32'h0000_0000, 6, 32'h0);
    for (int i = 0; i < 20; i++) fetch(32'h4 + 32'(4 * (i % 7)), 0, 32'h0);
    counts(15, 1);

    @(negedge CLK);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
